// File: rtl/usb_phy_pkg.sv
// usb_phy_pkg: shared definitions for the USB PHY receive path.
//   rx_state_e     - receive sequencer state encoding
//   STUFF_LIMIT    - longest legal run of decoded 1s inside a packet
//   MAX_PKT_BYTES  - longest legal packet, PID through CRC
package usb_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DATA     = 3'd1,
        ST_EOP1     = 3'd2,
        ST_EOP2     = 3'd3,
        ST_WAIT_EOP = 3'd4
    } rx_state_e;

    localparam int STUFF_LIMIT   = 6;
    localparam int MAX_PKT_BYTES = 1027;

endpackage

// File: rtl/usb_rx_byte_asm.sv
// usb_rx_byte_asm: assembles unstuffed bits (LSB first) into bytes.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start          - clear shift register, bit count and length (SYNC accept)
//   accept         - controller state allows bits to be assembled
//   us_bit         - unstuffed bit from the unstuffer
//   us_valid       - unstuffer shift enable
//   drop           - packet is being aborted this cycle; do not deliver
//   overflow       - a byte is completing while rx_len is already MAX_BYTES
//   bit_cnt_zero   - no partial byte is pending
//   rx_data        - last delivered byte
//   rx_valid       - one-cycle pulse, rx_data valid
//   rx_len         - number of bytes delivered in this packet
module usb_rx_byte_asm
    import usb_phy_pkg::*;
#(
    parameter int MAX_BYTES = MAX_PKT_BYTES,
    parameter int LEN_W     = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             accept,
    input  logic             us_bit,
    input  logic             us_valid,
    input  logic             drop,
    output logic             overflow,
    output logic             bit_cnt_zero,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [LEN_W-1:0] rx_len
);

    logic [7:0] shreg;
    logic [2:0] bit_cnt;
    logic       shift_en;
    logic       byte_done;
    logic [7:0] next_byte;

    assign shift_en     = us_valid & accept;
    assign byte_done    = shift_en & (bit_cnt == 3'd7);
    assign overflow     = byte_done & (rx_len == LEN_W'(MAX_BYTES));
    assign bit_cnt_zero = (bit_cnt == 3'd0);
    // Wire order is LSB first, so new bits enter at the MSB and move down.
    assign next_byte    = {us_bit, shreg[7:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            rx_len   <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (start) begin
                shreg   <= '0;
                bit_cnt <= '0;
                rx_len  <= '0;
            end else if (shift_en) begin
                shreg   <= next_byte;
                bit_cnt <= bit_cnt + 3'd1;  // wraps to 0 on the eighth bit
                if (byte_done && !overflow && !drop) begin
                    rx_data  <= next_byte;
                    rx_valid <= 1'b1;
                    rx_len   <= rx_len + LEN_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive-path sequencer between the NRZI decoder and the
// packet layer. Hunts SYNC, gates the bit unstuffer, assembles bytes,
// detects EOP and flags stuff, framing and length errors.
// Ports:
//   clk, reset           - clock, synchronous active-high reset
//   bit_strobe           - one pulse per USB bit time
//   dec_bit, se0         - decoded bit and SE0 flag, valid with bit_strobe
//   us_enable            - data_enable to the unstuffer (combinational)
//   us_bit, us_valid     - unstuffer output bit and shift enable
//   rx_active            - packet in progress (SYNC accept to EOP/abort)
//   rx_data, rx_valid    - delivered byte and its one-cycle strobe
//   rx_eop, rx_error     - one-cycle end-of-packet / abort pulses
//   rx_len               - bytes delivered in the current/last packet
//   dbg_state            - current sequencer state
// Handshake: rx_valid/rx_eop/rx_error are single-cycle strobes with no
// back-pressure; the consumer must take rx_data in the cycle rx_valid is 1.
module usb_rx_ctrl
    import usb_phy_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int MAX_BYTES      = MAX_PKT_BYTES,
    parameter int LEN_W          = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_strobe,
    input  logic             dec_bit,
    input  logic             se0,
    output logic             us_enable,
    input  logic             us_bit,
    input  logic             us_valid,
    output logic             rx_active,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_eop,
    output logic             rx_error,
    output logic [LEN_W-1:0] rx_len,
    output rx_state_e        dbg_state
);

    localparam logic [2:0] SYNC_MIN  = 3'(SYNC_MIN_ZEROS);
    localparam logic [2:0] ONES_LIM  = 3'(STUFF_LIMIT);

    rx_state_e  state, state_next;
    logic [2:0] zero_cnt;
    logic [2:0] ones_cnt;
    logic       seen_se0;       // WAIT_EOP: SE0 already observed
    logic       sync_hit;
    logic       err_next;
    logic       eop_next;
    logic       overflow;
    logic       bit_cnt_zero;
    logic       accept;

    assign us_enable = bit_strobe & ~se0 & (state == ST_DATA);
    assign rx_active = (state != ST_IDLE);
    assign dbg_state = state;
    // EOP1 still accepts bits: the unstuffer's last shift_en lags its strobe.
    assign accept    = (state == ST_DATA) | (state == ST_EOP1);

    always_comb begin
        state_next = state;
        sync_hit   = 1'b0;
        err_next   = 1'b0;
        eop_next   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bit_strobe && !se0 && dec_bit && zero_cnt >= SYNC_MIN) begin
                    state_next = ST_DATA;
                    sync_hit   = 1'b1;
                end
            end
            ST_DATA: begin
                if (overflow) begin
                    err_next   = 1'b1;
                    state_next = ST_WAIT_EOP;
                end else if (bit_strobe) begin
                    if (se0) begin
                        state_next = ST_EOP1;
                    end else if (dec_bit && ones_cnt == ONES_LIM) begin
                        err_next   = 1'b1;
                        state_next = ST_WAIT_EOP;
                    end
                end
            end
            ST_EOP1: begin
                if (overflow) begin
                    err_next   = 1'b1;
                    state_next = ST_WAIT_EOP;
                end else if (bit_strobe) begin
                    if (se0) begin
                        state_next = ST_EOP2;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_WAIT_EOP;
                    end
                end
            end
            ST_EOP2: begin
                if (bit_strobe && !se0) begin
                    state_next = ST_IDLE;
                    eop_next   = bit_cnt_zero;
                    err_next   = ~bit_cnt_zero;
                end
            end
            ST_WAIT_EOP: begin
                if (bit_strobe && !se0 && seen_se0) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            zero_cnt <= '0;
            ones_cnt <= '0;
            seen_se0 <= 1'b0;
            rx_eop   <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            state    <= state_next;
            rx_eop   <= eop_next;
            rx_error <= err_next;

            if (state != ST_IDLE) begin
                zero_cnt <= '0;
            end else if (bit_strobe) begin
                if (se0 || dec_bit) begin
                    zero_cnt <= '0;
                end else if (zero_cnt != 3'd7) begin
                    zero_cnt <= zero_cnt + 3'd1;
                end
            end

            if (sync_hit) begin
                ones_cnt <= '0;
            end else if (state == ST_DATA && bit_strobe && !se0) begin
                if (!dec_bit) begin
                    ones_cnt <= '0;
                end else if (ones_cnt != 3'd7) begin
                    ones_cnt <= ones_cnt + 3'd1;
                end
            end

            if (state != ST_WAIT_EOP) begin
                seen_se0 <= 1'b0;
            end else if (bit_strobe && se0) begin
                seen_se0 <= 1'b1;
            end
        end
    end

    usb_rx_byte_asm #(
        .MAX_BYTES (MAX_BYTES),
        .LEN_W     (LEN_W)
    ) u_byte_asm (
        .clk          (clk),
        .reset        (reset),
        .start        (sync_hit),
        .accept       (accept),
        .us_bit       (us_bit),
        .us_valid     (us_valid),
        .drop         (err_next),
        .overflow     (overflow),
        .bit_cnt_zero (bit_cnt_zero),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_len       (rx_len)
    );

endmodule
